// File: rtl/uart_spi_bridge.sv
// UART RX -> FIFO -> SPI slave (mode 0), SPI slave -> UART TX.
// Define UART_PARITY_EN to add an even-parity bit to both UART directions.
module uart_spi_bridge #(
   parameter int DATA_W     = 8,
   parameter int FIFO_DEPTH = 4,
   parameter int DIV_BASE   = 104
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [1:0]                    baud_sel,
   input  logic                          uart_rx,
   output logic                          uart_tx,
   input  logic                          cs_n,
   input  logic                          sclk,
   input  logic                          mosi,
   output logic                          miso,
   output logic [DATA_W-1:0]             spi_rx_data,
   output logic                          spi_rx_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
   output logic                          tx_busy,
   output logic                          err_ovf,
   output logic                          err_udf,
   output logic                          err_frame,
   output logic                          err_txdrop
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(DIV_BASE + 1);
   localparam int BW = $clog2(DATA_W + 1);
   localparam logic [CW-1:0] DIV_W = CW'(DIV_BASE);
   localparam logic [BW-1:0] LAST  = BW'(DATA_W - 1);

   // [1] is the synchronized value, [2] its previous value for edge detect
   logic [2:0] rx_q, cs_q, sck_q;
   logic [1:0] mosi_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_q   <= 3'b111;
         cs_q   <= 3'b111;
         sck_q  <= 3'b000;
         mosi_q <= 2'b00;
      end else begin
         rx_q   <= {rx_q[1:0], uart_rx};
         cs_q   <= {cs_q[1:0], cs_n};
         sck_q  <= {sck_q[1:0], sclk};
         mosi_q <= {mosi_q[0], mosi};
      end
   end

   logic rx_s, rx_fall, cs_s, sck_rise, sck_fall, mosi_s;
   assign rx_s     = rx_q[1];
   assign rx_fall  = rx_q[2] & ~rx_q[1];
   assign cs_s     = cs_q[1];
   assign sck_rise = ~sck_q[2] & sck_q[1];
   assign sck_fall = sck_q[2] & ~sck_q[1];
   assign mosi_s   = mosi_q[1];

   typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PAR, R_STOP} rx_st_t;
   rx_st_t            rx_st;
   logic [CW-1:0]     rx_div, rx_cnt;
   logic [BW-1:0]     rx_bit;
   logic [DATA_W-1:0] rx_sr;
   logic              rx_push, rx_tick, rx_ok;

   assign rx_tick = rx_cnt == rx_div - CW'(1);
`ifdef UART_PARITY_EN
   logic rx_perr;
   assign rx_ok = rx_s & ~rx_perr;
`else
   assign rx_ok = rx_s;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_st     <= R_IDLE;
         rx_div    <= '0;
         rx_cnt    <= '0;
         rx_bit    <= '0;
         rx_sr     <= '0;
         rx_push   <= 1'b0;
         err_frame <= 1'b0;
`ifdef UART_PARITY_EN
         rx_perr   <= 1'b0;
`endif
      end else begin
         rx_push   <= 1'b0;
         err_frame <= 1'b0;
         if (rx_st != R_IDLE) rx_cnt <= rx_cnt + CW'(1);
         unique case (rx_st)
            R_IDLE: if (rx_fall) begin
               rx_div <= DIV_W >> baud_sel;
               rx_cnt <= '0;
               rx_st  <= R_START;
            end
            R_START: if (rx_cnt == (rx_div >> 1) - CW'(1)) begin
               rx_cnt <= '0;
               rx_bit <= '0;
               rx_st  <= rx_s ? R_IDLE : R_DATA;
            end
            R_DATA: if (rx_tick) begin
               rx_cnt <= '0;
               rx_sr  <= {rx_s, rx_sr[DATA_W-1:1]};
               rx_bit <= rx_bit + BW'(1);
               if (rx_bit == LAST)
`ifdef UART_PARITY_EN
                  rx_st <= R_PAR;
`else
                  rx_st <= R_STOP;
`endif
            end
            R_PAR: if (rx_tick) begin
               rx_cnt  <= '0;
`ifdef UART_PARITY_EN
               rx_perr <= rx_s ^ (^rx_sr);
`endif
               rx_st   <= R_STOP;
            end
            R_STOP: if (rx_tick) begin
               rx_st <= R_IDLE;
               if (rx_ok) rx_push   <= 1'b1;
               else       err_frame <= 1'b1;
            end
            default: rx_st <= R_IDLE;
         endcase
      end
   end

   logic [DATA_W-1:0] mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [AW:0]       count;
   logic [DATA_W-1:0] head;
   logic              pop_req, pop_ok, push_ok, full, spi_done;

   assign head    = mem[rd_ptr];
   assign full    = count == (AW+1)'(FIFO_DEPTH);
   assign pop_req = ~cs_q[1] & (cs_q[2] | (sck_fall & spi_done));
   assign pop_ok  = pop_req & (count != '0);
   // a pop in the same cycle frees the slot a push into a full FIFO needs
   assign push_ok = rx_push & (~full | pop_ok);
   assign fifo_count = count;

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= rx_sr;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         err_ovf <= 1'b0;
      end else begin
         err_ovf <= rx_push & ~push_ok;
         if (push_ok) wr_ptr <= wr_ptr + AW'(1);
         if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
         if (push_ok & ~pop_ok)      count <= count + (AW+1)'(1);
         else if (~push_ok & pop_ok) count <= count - (AW+1)'(1);
      end
   end

   logic [DATA_W-1:0] spi_tx_sr, spi_rx_sr;
   logic [BW-1:0]     spi_bit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         spi_tx_sr    <= '0;
         spi_rx_sr    <= '0;
         spi_bit      <= '0;
         spi_done     <= 1'b0;
         miso         <= 1'b0;
         spi_rx_data  <= '0;
         spi_rx_valid <= 1'b0;
         err_udf      <= 1'b0;
      end else begin
         spi_rx_valid <= 1'b0;
         err_udf      <= 1'b0;
         if (cs_s) begin
            spi_bit  <= '0;
            spi_done <= 1'b0;
            miso     <= 1'b0;
         end else if (pop_req) begin
            spi_tx_sr <= pop_ok ? head : '0;
            miso      <= pop_ok & head[DATA_W-1];
            err_udf   <= ~pop_ok;
            spi_done  <= 1'b0;
         end else if (sck_rise) begin
            spi_rx_sr <= {spi_rx_sr[DATA_W-2:0], mosi_s};
            if (spi_bit == LAST) begin
               spi_bit      <= '0;
               spi_done     <= 1'b1;
               spi_rx_data  <= {spi_rx_sr[DATA_W-2:0], mosi_s};
               spi_rx_valid <= 1'b1;
            end else begin
               spi_bit <= spi_bit + BW'(1);
            end
         end else if (sck_fall) begin
            spi_tx_sr <= spi_tx_sr << 1;
            miso      <= spi_tx_sr[DATA_W-2];
         end
      end
   end

   typedef enum logic [2:0] {T_IDLE, T_START, T_DATA, T_PAR, T_STOP} tx_st_t;
   tx_st_t            tx_st;
   logic [CW-1:0]     tx_div, tx_cnt;
   logic [BW-1:0]     tx_bit;
   logic [DATA_W-1:0] tx_sr;
   logic              tx_tick;
`ifdef UART_PARITY_EN
   logic              tx_par;
`endif

   assign tx_tick = tx_cnt == tx_div - CW'(1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_st      <= T_IDLE;
         tx_div     <= '0;
         tx_cnt     <= '0;
         tx_bit     <= '0;
         tx_sr      <= '0;
         uart_tx    <= 1'b1;
         tx_busy    <= 1'b0;
         err_txdrop <= 1'b0;
`ifdef UART_PARITY_EN
         tx_par     <= 1'b0;
`endif
      end else begin
         err_txdrop <= spi_rx_valid & tx_busy;
         if (tx_st != T_IDLE) tx_cnt <= tx_tick ? '0 : tx_cnt + CW'(1);
         unique case (tx_st)
            T_IDLE: if (spi_rx_valid) begin
               tx_sr   <= spi_rx_data;
               tx_div  <= DIV_W >> baud_sel;
               tx_cnt  <= '0;
               tx_busy <= 1'b1;
               uart_tx <= 1'b0;
               tx_st   <= T_START;
`ifdef UART_PARITY_EN
               tx_par  <= ^spi_rx_data;
`endif
            end
            T_START: if (tx_tick) begin
               uart_tx <= tx_sr[0];
               tx_sr   <= tx_sr >> 1;
               tx_bit  <= '0;
               tx_st   <= T_DATA;
            end
            T_DATA: if (tx_tick) begin
               if (tx_bit == LAST) begin
`ifdef UART_PARITY_EN
                  uart_tx <= tx_par;
                  tx_st   <= T_PAR;
`else
                  uart_tx <= 1'b1;
                  tx_st   <= T_STOP;
`endif
               end else begin
                  uart_tx <= tx_sr[0];
                  tx_sr   <= tx_sr >> 1;
                  tx_bit  <= tx_bit + BW'(1);
               end
            end
            T_PAR: if (tx_tick) begin
               uart_tx <= 1'b1;
               tx_st   <= T_STOP;
            end
            T_STOP: if (tx_tick) begin
               tx_busy <= 1'b0;
               tx_st   <= T_IDLE;
            end
            default: tx_st <= T_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_spi_bridge.sv
// Directed bench for uart_spi_bridge (DATA_W=8, FIFO_DEPTH=4, DIV_BASE=16).
// Parity cases are compiled in only when UART_PARITY_EN is defined.
module tb_uart_spi_bridge;
   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [1:0] baud_sel = 2'd0;
   logic       uart_rx = 1'b1;
   logic       cs_n = 1'b1;
   logic       sclk = 1'b0;
   logic       mosi = 1'b0;
   logic       uart_tx, miso, spi_rx_valid, tx_busy;
   logic       err_ovf, err_udf, err_frame, err_txdrop;
   logic [7:0] spi_rx_data;
   logic [2:0] fifo_count;

   uart_spi_bridge #(.DATA_W(8), .FIFO_DEPTH(4), .DIV_BASE(16)) dut (
      .clk(clk), .rst_n(rst_n), .baud_sel(baud_sel),
      .uart_rx(uart_rx), .uart_tx(uart_tx),
      .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso),
      .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid),
      .fifo_count(fifo_count), .tx_busy(tx_busy),
      .err_ovf(err_ovf), .err_udf(err_udf),
      .err_frame(err_frame), .err_txdrop(err_txdrop)
   );

   always #5 clk = ~clk;

   int n_chk = 0, n_pass = 0;
   int n_ovf = 0, n_udf = 0, n_frm = 0, n_txd = 0, n_val = 0;
   logic [7:0] mw [4];
   logic [7:0] mr [4];
   logic [7:0] rb;
   logic       rok;
`ifdef UART_PARITY_EN
   logic       par_flip = 1'b0;
`endif

   always @(negedge clk) begin
      if (err_ovf)      n_ovf++;
      if (err_udf)      n_udf++;
      if (err_frame)    n_frm++;
      if (err_txdrop)   n_txd++;
      if (spi_rx_valid) n_val++;
   end

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   task automatic uart_send(input logic [7:0] d, input logic stop,
                            input int bt);
      @(negedge clk);
      uart_rx = 1'b0;
      repeat (bt) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         uart_rx = d[i];
         repeat (bt) @(negedge clk);
      end
`ifdef UART_PARITY_EN
      uart_rx = ^d ^ par_flip;
      repeat (bt) @(negedge clk);
`endif
      uart_rx = stop;
      repeat (bt) @(negedge clk);
      uart_rx = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic spi_frame(input int nw);
      @(negedge clk);
      cs_n = 1'b0;
      for (int w = 0; w < nw; w++) begin
         for (int b = 7; b >= 0; b--) begin
            mosi = mw[w][b];
            repeat (6) @(negedge clk);
            mr[w][b] = miso;
            sclk = 1'b1;
            repeat (5) @(negedge clk);
            if (!(w == nw - 1 && b == 0)) sclk = 1'b0;
         end
      end
      cs_n = 1'b1;
      repeat (5) @(negedge clk);
      sclk = 1'b0;
      mosi = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic uart_capture(output logic [7:0] d, output logic ok);
      logic seen;
      seen = 1'b0;
      d = 8'h00;
      ok = 1'b0;
      for (int i = 0; i < 3000 && !seen; i++) begin
         @(negedge clk);
         if (!uart_tx) seen = 1'b1;
      end
      if (seen) begin
         repeat (8) @(negedge clk);
         ok = !uart_tx;
         for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            d[i] = uart_tx;
         end
`ifdef UART_PARITY_EN
         repeat (16) @(negedge clk);
         ok = ok & (uart_tx == ^d);
`endif
         repeat (16) @(negedge clk);
         ok = ok & uart_tx;
      end
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 3000 && tx_busy; i++) @(negedge clk);
      chk("tx_idle", tx_busy, 0);
   endtask

   initial begin
      int u0, v0, t0, f0, s0, low;
      repeat (3) @(negedge clk);
      chk("rst_uart_tx", uart_tx, 1);
      chk("rst_miso", miso, 0);
      chk("rst_rx_data", spi_rx_data, 0);
      chk("rst_fifo", fifo_count, 0);
      chk("rst_busy", tx_busy, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      uart_send(8'hA5, 1'b1, 16);
      chk("fifo_a5", fifo_count, 1);
      mw[0] = 8'h00;
      spi_frame(1);
      chk("miso_a5", mr[0], 8'hA5);
      chk("fifo_after_pop", fifo_count, 0);
      wait_idle();

      for (int k = 1; k <= 5; k++) uart_send(8'(k), 1'b1, 16);
      chk("fifo_full", fifo_count, 4);
      chk("ovf_once", n_ovf, 1);
      mw[0] = 8'h11; mw[1] = 8'h22; mw[2] = 8'h33; mw[3] = 8'h44;
      spi_frame(4);
      chk("pop_w0", mr[0], 8'h01);
      chk("pop_w1", mr[1], 8'h02);
      chk("pop_w2", mr[2], 8'h03);
      chk("pop_w3", mr[3], 8'h04);
      chk("fifo_drained", fifo_count, 0);
      chk("no_udf", n_udf, 0);
      chk("rx_data_44", spi_rx_data, 8'h44);
      wait_idle();

      u0 = n_udf;
      mw[0] = 8'h3C;
      fork
         spi_frame(1);
         uart_capture(rb, rok);
      join
      chk("udf_pulse", n_udf - u0, 1);
      chk("miso_zero", mr[0], 0);
      chk("rx_data_3c", spi_rx_data, 8'h3C);
      chk("tx_byte_3c", rb, 8'h3C);
      chk("tx_frame_3c", rok, 1);
      wait_idle();

      v0 = n_val;
      t0 = n_txd;
      mw[0] = 8'h5A; mw[1] = 8'hC3;
      fork
         spi_frame(2);
         uart_capture(rb, rok);
      join
      chk("two_valid", n_val - v0, 2);
      chk("one_txdrop", n_txd - t0, 1);
      chk("tx_byte_5a", rb, 8'h5A);
      chk("rx_data_c3", spi_rx_data, 8'hC3);
      wait_idle();

      f0 = n_frm;
      uart_send(8'h55, 1'b0, 16);
      chk("frame_err", n_frm - f0, 1);
      chk("frame_no_push", fifo_count, 0);

      mw[0] = 8'h00;
      spi_frame(1);
      repeat (20) @(negedge clk);
      chk("busy_mid_tx", tx_busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("rst_tx_high", uart_tx, 1);
      chk("rst_tx_busy", tx_busy, 0);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      s0 = n_ovf + n_udf + n_frm + n_txd + n_val;
      low = 0;
      repeat (200) begin
         @(negedge clk);
         if (!uart_tx) low++;
      end
      chk("post_rst_tx_low", low, 0);
      chk("post_rst_pulses", n_ovf + n_udf + n_frm + n_txd + n_val - s0, 0);

      baud_sel = 2'd1;
      uart_send(8'h3C, 1'b1, 8);
      chk("fifo_baud1", fifo_count, 1);
      mw[0] = 8'h00;
      spi_frame(1);
      chk("miso_baud1", mr[0], 8'h3C);
      wait_idle();
      baud_sel = 2'd0;

`ifdef UART_PARITY_EN
      f0 = n_frm;
      par_flip = 1'b1;
      uart_send(8'h07, 1'b1, 16);
      chk("par_bad_err", n_frm - f0, 1);
      chk("par_bad_fifo", fifo_count, 0);
      par_flip = 1'b0;
      uart_send(8'h07, 1'b1, 16);
      chk("par_good_fifo", fifo_count, 1);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
